// File: rtl/replace_num_sched_pkg.sv
// +----------------------------------------------------------------------+
// | replace_num_sched_pkg : shared widths and helpers for the scheduler  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package replace_num_sched_pkg;

    // Packet layout is {addr, data}, matching the UART message decoder.
    localparam int PKT_ADDR_WIDTH  = 8;
    localparam int PKT_DATA_WIDTH  = 16;
    localparam int PEND_FIFO_DEPTH = 4;
    localparam int REPL_CNT_WIDTH  = 16;

    localparam logic [1:0] STROBE_GAP_MIN = 2'd2;
    localparam logic [1:0] STROBE_GAP_SAT = 2'd3;

    function automatic logic [REPL_CNT_WIDTH-1:0] sat_inc(input logic [REPL_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + REPL_CNT_WIDTH'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/replace_num_fifo.sv
// +----------------------------------------------------------------------+
// | replace_num_fifo : synchronous pending-write FIFO with count flags   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module replace_num_fifo
    import replace_num_sched_pkg::*;
#(
    parameter int WIDTH = PKT_ADDR_WIDTH + PKT_DATA_WIDTH,
    parameter int DEPTH = PEND_FIFO_DEPTH
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/replace_num_sched.sv
// +----------------------------------------------------------------------+
// | replace_num_sched : replacement-memory read/write scheduler          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module replace_num_sched
    import replace_num_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = PKT_ADDR_WIDTH,
    parameter int DATA_WIDTH = PKT_DATA_WIDTH,
    parameter int FIFO_DEPTH = PEND_FIFO_DEPTH
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] pkt_in,
    input  logic                             pkt_valid,
    output logic                             pkt_ready,
    input  logic                             word_strobe,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_wr_packet,
    output logic                             mem_wr_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    output logic                             mem_rd_en,
    input  logic [DATA_WIDTH-1:0]            mem_data,
    input  logic                             mem_valid,
    output logic [DATA_WIDTH-1:0]            repl_data,
    output logic                             repl_valid,
    output logic [ADDR_WIDTH-1:0]            pos,
    output logic [$clog2(FIFO_DEPTH):0]      pending,
    output logic [REPL_CNT_WIDTH-1:0]        replaced_cnt,
    output logic                             overrun
);

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_block;

    logic [ADDR_WIDTH-1:0]     pos_q,     pos_d;
    logic [1:0]                gap_q,     gap_d;
    logic                      overrun_q, overrun_d;
    logic [REPL_CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic                      rd_en_q;
    logic [ADDR_WIDTH-1:0]     rd_addr_q;
    logic                      rd_pend_q;
    logic                      clear_q;
    logic                      first_q;
    logic                      repl_valid_q;
    logic [DATA_WIDTH-1:0]     repl_data_q;

    // Writes stay off the read cycle, the memory's clear slot after it,
    // and the first cycle out of reset.
    assign w_block = rd_en_q | clear_q | first_q;
    assign w_push  = pkt_valid && !w_full;
    assign w_pop   = !w_empty && !w_block;

    replace_num_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (pkt_in),
        .rdata_o (mem_wr_packet),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (pending)
    );

    always_comb begin
        pos_d     = pos_q;
        gap_d     = gap_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        if (word_strobe) begin
            pos_d = pos_q + ADDR_WIDTH'(1);
            gap_d = 2'd0;
            if (gap_q < STROBE_GAP_MIN) overrun_d = 1'b1;
        end else if (gap_q != STROBE_GAP_SAT) begin
            gap_d = gap_q + 2'd1;
        end
        if (repl_valid_q) cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q        <= '0;
            gap_q        <= STROBE_GAP_SAT;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_pend_q    <= 1'b0;
            clear_q      <= 1'b0;
            first_q      <= 1'b1;
            repl_valid_q <= 1'b0;
            repl_data_q  <= '0;
        end else begin
            pos_q        <= pos_d;
            gap_q        <= gap_d;
            overrun_q    <= overrun_d;
            cnt_q        <= cnt_d;
            first_q      <= 1'b0;
            rd_en_q      <= word_strobe;
            clear_q      <= rd_en_q;
            if (word_strobe) rd_addr_q <= pos_q;
            // A strobe right behind a read supersedes it; its data is dropped.
            rd_pend_q    <= rd_en_q && !word_strobe;
            repl_valid_q <= rd_pend_q && mem_valid;
            if (rd_pend_q) repl_data_q <= mem_data;
        end
    end

    assign pkt_ready    = !w_full;
    assign mem_wr_en    = w_pop;
    assign mem_rd_en    = rd_en_q;
    assign mem_rd_addr  = rd_addr_q;
    assign repl_valid   = repl_valid_q;
    assign repl_data    = repl_data_q;
    assign pos          = pos_q;
    assign replaced_cnt = cnt_q;
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_replace_num_sched.sv
// +----------------------------------------------------------------------+
// | tb_replace_num_sched : randomized bench with a queue-based model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_replace_num_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] pkt_in = '0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic        word_strobe = 1'b0;
    logic [23:0] mem_wr_packet;
    logic        mem_wr_en;
    logic [7:0]  mem_rd_addr;
    logic        mem_rd_en;
    logic [15:0] mem_data = '0;
    logic        mem_valid = 1'b0;
    logic [15:0] repl_data;
    logic        repl_valid;
    logic [7:0]  pos;
    logic [2:0]  pending;
    logic [15:0] replaced_cnt;
    logic        overrun;

    always #5 clk = ~clk;

    replace_num_sched dut (
        .clk(clk), .rst(rst), .pkt_in(pkt_in), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .word_strobe(word_strobe),
        .mem_wr_packet(mem_wr_packet), .mem_wr_en(mem_wr_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .repl_data(repl_data), .repl_valid(repl_valid), .pos(pos),
        .pending(pending), .replaced_cnt(replaced_cnt), .overrun(overrun)
    );

    // Replacement memory: registered read that clears the valid flag.
    logic [15:0] tmem_d [256] = '{default: 16'h0};
    logic        tmem_v [256] = '{default: 1'b0};

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_data              <= tmem_d[mem_rd_addr];
            mem_valid             <= tmem_v[mem_rd_addr];
            tmem_v[mem_rd_addr]   <= 1'b0;
        end
        if (mem_wr_en) begin
            tmem_d[mem_wr_packet[23:16]] <= mem_wr_packet[15:0];
            tmem_v[mem_wr_packet[23:16]] <= 1'b1;
        end
    end

    typedef struct {
        bit          v;
        logic [15:0] d;
    } repl_t;

    // Reference model: cycle-indexed event maps and a packet queue.
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           rel_cyc = 0;
    int           last_strobe = -100;
    logic [23:0]  q[$];
    logic [7:0]   exp_rd [int];
    repl_t        exp_repl [int];
    bit   [15:0]  ref_d [256];
    bit           ref_v [256];
    logic [7:0]   m_pos = '0;
    bit           m_ovr = 1'b0;
    logic [15:0]  m_cnt = '0;
    logic [15:0]  m_rdata = '0;
    bit           m_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit pv, input logic [23:0] pk);
        bit          e_rd;
        bit          e_wr;
        bit          blk;
        bit          e_rv;
        bit          ready;
        logic [23:0] head;
        logic [7:0]  a;
        @(negedge clk);
        e_rd  = exp_rd.exists(cyc);
        blk   = e_rd || exp_rd.exists(cyc - 1) || (cyc == rel_cyc);
        e_wr  = !blk && (q.size() > 0);
        ready = (q.size() < 4);
        e_rv  = 1'b0;
        if (exp_repl.exists(cyc)) begin
            e_rv    = exp_repl[cyc].v;
            m_rdata = exp_repl[cyc].d;
        end
        chk("rd_en", mem_rd_en, e_rd);
        if (e_rd) chk("rd_addr", mem_rd_addr, exp_rd[cyc]);
        chk("wr_en", mem_wr_en, e_wr);
        if (e_wr) chk("wr_packet", mem_wr_packet, q[0]);
        chk("repl_valid", repl_valid, e_rv);
        chk("repl_data", repl_data, m_rdata);
        chk("pending", pending, q.size());
        chk("pkt_ready", pkt_ready, ready);
        chk("pos", pos, m_pos);
        chk("overrun", overrun, m_ovr);
        chk("replaced_cnt", replaced_cnt, m_cnt);

        rst = r; word_strobe = s; pkt_valid = pv; pkt_in = pk;

        if (e_rd) begin
            a = exp_rd[cyc];
            if (!s && !r) exp_repl[cyc + 2] = '{ref_v[a], ref_d[a]};
            ref_v[a] = 1'b0;
        end
        if (e_wr) begin
            head = q.pop_front();
            ref_d[head[23:16]] = head[15:0];
            ref_v[head[23:16]] = 1'b1;
        end
        m_acc = pv && ready && !r;
        if (m_acc) q.push_back(pk);
        if (s) begin
            exp_rd[cyc + 1] = m_pos;
            if (cyc - last_strobe <= 2) m_ovr = 1'b1;
            m_pos = m_pos + 8'd1;
            last_strobe = cyc;
        end
        if (e_rv && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (r) begin
            q.delete(); exp_rd.delete(); exp_repl.delete();
            m_pos = '0; m_ovr = 1'b0; m_cnt = '0; m_rdata = '0;
            last_strobe = -100;
            rel_cyc = cyc + 1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        int          sent;
        logic [23:0] rp;
        bit          rs;
        repeat (2) @(posedge clk);

        // Single write after reset release.
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b1, {8'h05, 16'hBEEF});
        idle(4);

        // Write addr 3, then four widely spaced strobes.
        step(1'b0, 1'b0, 1'b1, {8'h03, 16'h1234});
        idle(3);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 24'h0);
            idle(7);
        end
        chk("cnt_after_addr3", replaced_cnt, 16'd1);

        // Back-to-back packets against strobes every 3 cycles.
        sent = 0;
        for (int i = 0; i < 60 && sent < 6; i++) begin
            step(1'b0, (i % 3) == 0, 1'b1, {8'h40 + 8'(sent), 16'hA000 + 16'(sent)});
            if (m_acc) sent++;
        end
        chk("six_accepted", sent, 6);
        idle(12);

        // Full position sweep and wrap.
        step(1'b1, 1'b0, 1'b0, 24'h0);
        for (int k = 0; k < 257; k++) begin
            step(1'b0, 1'b1, 1'b0, 24'h0);
            idle(2);
        end
        idle(3);

        // Strobes one cycle apart.
        step(1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b1, 1'b0, 24'h0);
        idle(6);

        // Randomized traffic.
        step(1'b1, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 1500; i++) begin
            rs = ((cyc - last_strobe) >= 3) ? ($urandom_range(0, 3) == 0)
                                            : ($urandom_range(0, 63) == 0);
            rp = 24'($urandom);
            step(1'b0, rs, $urandom_range(0, 1) == 1, rp);
        end
        idle(6);

        // Reset with packets pending and a read in flight.
        for (int i = 0; i < 5; i++)
            step(1'b0, (i % 2) == 0, (i >= 1 && i <= 3), {8'h80 + 8'(i), 16'h5500 + 16'(i)});
        chk("pending_before_rst", pending, 3'd3);
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 1'b0, 24'h0);
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
